// File: rtl/galvo_pid_pkg.sv
// Shared definitions for the galvo PID loop: FSM encodings, config select
// codes and small elaboration-time helpers.
package galvo_pid_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ERR  = 3'd1;
   localparam logic [2:0] ST_MUL  = 3'd2;
   localparam logic [2:0] ST_SUM  = 3'd3;
   localparam logic [2:0] ST_OUT  = 3'd4;

   localparam logic [2:0] CFG_SEL_KP   = 3'd0;
   localparam logic [2:0] CFG_SEL_KI   = 3'd1;
   localparam logic [2:0] CFG_SEL_KD   = 3'd2;
   localparam logic [2:0] CFG_SEL_DLIM = 3'd3;
   localparam logic [2:0] CFG_SEL_ISAT = 3'd4;
   localparam logic [2:0] CFG_SEL_DB   = 3'd5;
   localparam logic [2:0] CFG_SEL_CLR  = 3'd7;

   // Channel index width; never below 1 so a single-axis build still has a port.
   function automatic int CLOG2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 16; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned MID(input int dw);
      return 32'd1 << (dw - 1);
   endfunction

endpackage

// File: rtl/galvo_pid_mc_if.sv
// Bus bundle between the PID controller and its environment: config, target,
// ADC sample and DAC result channels, plus status and FSM debug state.
interface galvo_pid_mc_if
   import galvo_pid_pkg::*;
#(
   parameter int NCH = 2,
   parameter int DW  = 16,
   parameter int AW  = 32
);

   localparam int CW = CLOG2(NCH);

   // Strobes are single-cycle; there is no back-pressure. A sample presented
   // while busy is dropped and recorded in the sticky overrun flag.
   logic          cfg_we;
   logic [CW-1:0] cfg_ch;
   logic [2:0]    cfg_sel;
   logic [AW-1:0] cfg_data;
   logic          tgt_valid;
   logic [CW-1:0] tgt_ch;
   logic [DW-1:0] tgt_data;
   logic          adc_valid;
   logic [CW-1:0] adc_ch;
   logic [DW-1:0] adc_data;
   logic          dac_valid;
   logic [CW-1:0] dac_ch;
   logic [DW-1:0] dac_data;
   logic          busy;
   logic          overrun;
   logic [2:0]    dbg_state;

   modport master (
      output cfg_we, cfg_ch, cfg_sel, cfg_data,
      output tgt_valid, tgt_ch, tgt_data,
      output adc_valid, adc_ch, adc_data,
      input  dac_valid, dac_ch, dac_data, busy, overrun, dbg_state
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_sel, cfg_data,
      input  tgt_valid, tgt_ch, tgt_data,
      input  adc_valid, adc_ch, adc_data,
      output dac_valid, dac_ch, dac_data, busy, overrun, dbg_state
   );

endinterface

// File: rtl/galvo_pid_sat.sv
// Signed symmetric clamp: y = x limited to [-lim, +lim]; lim is a non-negative
// magnitude. Purely combinational.
module galvo_pid_sat #(
   parameter int W = 34
) (
   input  logic signed [W-1:0] x_i,
   input  logic        [W-1:0] lim_i,
   output logic signed [W-1:0] y_o
);

   logic signed [W-1:0] pos_lim;
   logic signed [W-1:0] neg_lim;

   always_comb begin
      pos_lim = signed'(lim_i);
      neg_lim = -pos_lim;
      y_o     = x_i;
      if (x_i > pos_lim) begin
         y_o = pos_lim;
      end else if (x_i < neg_lim) begin
         y_o = neg_lim;
      end
   end

endmodule

// File: rtl/galvo_pid_mc.sv
// Time-multiplexed multi-axis position PID producing offset-binary DAC codes.
// Optional deadband on the error term is enabled by defining PID_DEADBAND_EN.
module galvo_pid_mc
   import galvo_pid_pkg::*;
#(
   parameter int NCH  = 2,
   parameter int DW   = 16,
   parameter int GW   = 16,
   parameter int AW   = 32,
   parameter int P_SH = 10,
   parameter int I_SH = 10,
   parameter int D_SH = 8
) (
   input  logic          clk_pid,
   input  logic          sys_rstn,
   galvo_pid_mc_if.slave bus
);

   localparam int            CW      = CLOG2(NCH);
   localparam int            PW      = GW + AW + 2;
   localparam logic [DW-1:0] MID_C   = DW'(MID(DW));
   localparam logic [DW-1:0] LIM_MAX = MID_C - 1'b1;
   localparam logic [CW:0]   NCH_W   = (CW + 1)'(NCH);

   // Per-channel configuration and loop state.
   logic [GW-1:0]        kp_q    [NCH];
   logic [GW-1:0]        ki_q    [NCH];
   logic [GW-1:0]        kd_q    [NCH];
   logic [DW-1:0]        dlim_q  [NCH];
   logic [AW-2:0]        isat_q  [NCH];
   logic [DW-1:0]        tgt_q   [NCH];
   logic signed [AW-1:0] integ_q [NCH];
   logic signed [AW-1:0] elast_q [NCH];
   logic [NCH-1:0]       first_q;
`ifdef PID_DEADBAND_EN
   logic [DW-1:0]        db_q    [NCH];
`endif

   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        ch_q;
   logic signed [AW-1:0] e_q;
   logic signed [AW-1:0] p_q, i_q, d_q;
   logic [DW-1:0]        lim_q;
   logic signed [AW+1:0] u_q;
   logic                 dac_valid_q;
   logic [CW-1:0]        dac_ch_q;
   logic [DW-1:0]        dac_data_q;
   logic                 overrun_q;

   logic                 accept;
   logic                 cfg_ok, tgt_ok;
   logic signed [AW-1:0] e_raw, e_new;
   logic signed [AW:0]   isum, isat_y;
   logic signed [AW-1:0] integ_new;
   logic signed [AW:0]   de;
   logic signed [PW-1:0] p_prod, i_prod, d_prod;
   logic signed [PW-1:0] p_sh, i_sh, d_sh;
   logic signed [AW+1:0] u_sum, u_sat;
   logic [DW-1:0]        code;

   assign accept = bus.adc_valid && (state_q == ST_IDLE) && ({1'b0, bus.adc_ch} < NCH_W);
   assign cfg_ok = ({1'b0, bus.cfg_ch} < NCH_W);
   assign tgt_ok = ({1'b0, bus.tgt_ch} < NCH_W);

   assign e_raw = signed'(AW'(tgt_q[bus.adc_ch])) - signed'(AW'(bus.adc_data));

`ifdef PID_DEADBAND_EN
   logic signed [AW-1:0] e_abs;
   always_comb begin
      e_abs = e_raw[AW-1] ? -e_raw : e_raw;
      e_new = (e_abs <= signed'(AW'(db_q[bus.adc_ch]))) ? '0 : e_raw;
   end
`else
   assign e_new = e_raw;
`endif

   // Integrator accumulates in one extra bit so the clamp sees the true sum.
   assign isum = {integ_q[ch_q][AW-1], integ_q[ch_q]} + {e_q[AW-1], e_q};

   galvo_pid_sat #(.W(AW + 1)) u_isat (
      .x_i   (isum),
      .lim_i ((AW + 1)'(isat_q[ch_q])),
      .y_o   (isat_y)
   );

   assign integ_new = isat_y[AW-1:0];
   assign de        = first_q[ch_q] ? '0 : ({e_q[AW-1], e_q} - {elast_q[ch_q][AW-1], elast_q[ch_q]});

   assign p_prod = PW'($signed({1'b0, kp_q[ch_q]})) * PW'(e_q);
   assign i_prod = PW'($signed({1'b0, ki_q[ch_q]})) * PW'(integ_new);
   assign d_prod = PW'($signed({1'b0, kd_q[ch_q]})) * PW'(de);
   assign p_sh   = p_prod >>> P_SH;
   assign i_sh   = i_prod >>> I_SH;
   assign d_sh   = d_prod >>> D_SH;

   assign u_sum = (AW + 2)'(p_q) + (AW + 2)'(i_q) + (AW + 2)'(d_q);

   galvo_pid_sat #(.W(AW + 2)) u_osat (
      .x_i   (u_q),
      .lim_i ((AW + 2)'(lim_q)),
      .y_o   (u_sat)
   );

   // lim_q < MID, so the wrapped low bits added to MID stay inside the code range.
   assign code = MID_C + u_sat[DW-1:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_ERR;
         ST_ERR:  state_d = ST_MUL;
         ST_MUL:  state_d = ST_SUM;
         ST_SUM:  state_d = ST_OUT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_pid) begin
      if (!sys_rstn) begin
         for (int c = 0; c < NCH; c++) begin
            kp_q[c]    <= '0;
            ki_q[c]    <= '0;
            kd_q[c]    <= '0;
            dlim_q[c]  <= '0;
            isat_q[c]  <= '0;
            tgt_q[c]   <= MID_C;
            integ_q[c] <= '0;
            elast_q[c] <= '0;
`ifdef PID_DEADBAND_EN
            db_q[c]    <= '0;
`endif
         end
         first_q     <= '1;
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         e_q         <= '0;
         p_q         <= '0;
         i_q         <= '0;
         d_q         <= '0;
         lim_q       <= '0;
         u_q         <= '0;
         dac_valid_q <= 1'b0;
         dac_ch_q    <= '0;
         dac_data_q  <= MID_C;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         dac_valid_q <= 1'b0;

         if (bus.cfg_we && cfg_ok) begin
            case (bus.cfg_sel)
               CFG_SEL_KP:   kp_q[bus.cfg_ch]   <= bus.cfg_data[GW-1:0];
               CFG_SEL_KI:   ki_q[bus.cfg_ch]   <= bus.cfg_data[GW-1:0];
               CFG_SEL_KD:   kd_q[bus.cfg_ch]   <= bus.cfg_data[GW-1:0];
               CFG_SEL_DLIM: dlim_q[bus.cfg_ch] <= bus.cfg_data[DW-1:0];
               CFG_SEL_ISAT: isat_q[bus.cfg_ch] <= bus.cfg_data[AW-2:0];
`ifdef PID_DEADBAND_EN
               CFG_SEL_DB:   db_q[bus.cfg_ch]   <= bus.cfg_data[DW-1:0];
`endif
               default: ;
            endcase
         end

         if (bus.adc_valid && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
         end else if (bus.cfg_we && (bus.cfg_sel == CFG_SEL_CLR)) begin
            overrun_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  ch_q <= bus.adc_ch;
                  e_q  <= e_new;
               end
            end
            ST_ERR: begin
               integ_q[ch_q] <= integ_new;
               first_q[ch_q] <= 1'b0;
               p_q           <= p_sh[AW-1:0];
               i_q           <= i_sh[AW-1:0];
               d_q           <= d_sh[AW-1:0];
               lim_q         <= (dlim_q[ch_q] >= MID_C) ? LIM_MAX : dlim_q[ch_q];
            end
            ST_MUL: u_q <= u_sum;
            ST_SUM: begin
               dac_valid_q   <= 1'b1;
               dac_ch_q      <= ch_q;
               dac_data_q    <= code;
               elast_q[ch_q] <= e_q;
            end
            default: ;
         endcase

         // A target change overrides any same-cycle integrator or flag update.
         if (bus.tgt_valid && tgt_ok) begin
            tgt_q[bus.tgt_ch]   <= bus.tgt_data;
            integ_q[bus.tgt_ch] <= '0;
            first_q[bus.tgt_ch] <= 1'b1;
         end
      end
   end

   assign bus.dac_valid = dac_valid_q;
   assign bus.dac_ch    = dac_ch_q;
   assign bus.dac_data  = dac_data_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.overrun   = overrun_q;
   assign bus.dbg_state = state_q;

endmodule
